// File: rtl/spi_rx_ctrl.sv
// spi_rx_ctrl - transaction sequencer for the SPI receive datapath.
// Accepts a receive command (bit length, SCLK half-period divider),
// drives chip-select and SCLK (CPOL=0, sample on rising edge), programs
// the datapath bit length/enable and emits the per-bit sample strobe.
// SCLK is held low while the datapath reports idle at the end of a low
// phase, so a slow word consumer never loses a bit.
// Optional feature: define SPI_RX_CTRL_ABORT_EN to add abort_i/aborted_o.
module spi_rx_ctrl #(
  parameter int LEN_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cmd_vld_i,
  output logic             cmd_rdy_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [DIV_W-1:0] cmd_div_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             cs_n_o,
  output logic             sclk_o,
  output logic             rx_en_o,
  output logic             rx_edge_o,
  output logic [LEN_W-1:0] rx_bits_len_o,
  output logic             rx_bits_len_update_o,
`ifdef SPI_RX_CTRL_ABORT_EN
  input  logic             abort_i,
  output logic             aborted_o,
`endif
  input  logic             rx_idle_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] HCNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] HCNT_ZERO = {DIV_W{1'b0}};
  localparam logic [LEN_W-1:0] BIT_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] BIT_ZERO  = {LEN_W{1'b0}};

  state_t           state_r, state_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [DIV_W-1:0] hcnt_r, hcnt_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic [LEN_W-1:0] bit_cnt_r, bit_cnt_s;
  logic             cs_n_r, cs_n_s;
  logic             sclk_r, sclk_s;
  logic             edge_r, edge_s;
  logic             en_r, en_s;
  logic             upd_r, upd_s;
  logic             done_r, done_s;
  logic             hexp_s;
`ifdef SPI_RX_CTRL_ABORT_EN
  logic             abort_seen_r, abort_seen_s;
  logic             aborted_r, aborted_s;
`endif

  // Half-period expiry: the phase counter has spent div+1 cycles in this phase.
  assign hexp_s = (hcnt_r == div_r);

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    hcnt_s    = hcnt_r;
    len_s     = len_r;
    bit_cnt_s = bit_cnt_r;
    cs_n_s    = cs_n_r;
    sclk_s    = sclk_r;
    en_s      = en_r;
    edge_s    = 1'b0;
    upd_s     = 1'b0;
    done_s    = 1'b0;
`ifdef SPI_RX_CTRL_ABORT_EN
    abort_seen_s = abort_seen_r;
    aborted_s    = 1'b0;
`endif

    case (state_r)
      ST_IDLE: begin
        if (cmd_vld_i) begin
          len_s     = cmd_len_i;
          div_s     = cmd_div_i;
          hcnt_s    = HCNT_ZERO;
          bit_cnt_s = BIT_ZERO;
`ifdef SPI_RX_CTRL_ABORT_EN
          abort_seen_s = 1'b0;
`endif
          if (cmd_len_i == BIT_ZERO) begin
            // Empty transfer: complete immediately without touching CS.
            done_s = 1'b1;
          end else begin
            state_s = ST_SETUP;
            cs_n_s  = 1'b0;
            en_s    = 1'b1;
            upd_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (hexp_s) begin
          state_s = ST_RUN;
          hcnt_s  = HCNT_ZERO;
        end else begin
          hcnt_s = hcnt_r + HCNT_ONE;
        end
      end

      ST_RUN: begin
        if (sclk_r) begin
          // High phase: fall at expiry, leave after the last bit's fall.
          if (hexp_s) begin
            sclk_s = 1'b0;
            hcnt_s = HCNT_ZERO;
            if (bit_cnt_r == len_r) begin
              state_s = ST_HOLD;
              en_s    = 1'b0;
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            hcnt_s = hcnt_r + HCNT_ONE;
          end
        end else begin
          // Low phase: rise at expiry unless the datapath is still idle,
          // in which case the counter parks at expiry until it is ready.
          if (hexp_s) begin
            if (!rx_idle_i) begin
              sclk_s    = 1'b1;
              edge_s    = 1'b1;
              bit_cnt_s = bit_cnt_r + BIT_ONE;
              hcnt_s    = HCNT_ZERO;
            end else begin
              hcnt_s = hcnt_r;
            end
          end else begin
            hcnt_s = hcnt_r + HCNT_ONE;
          end
        end
      end

      ST_HOLD: begin
        if (hexp_s) begin
          state_s = ST_IDLE;
          cs_n_s  = 1'b1;
          done_s  = 1'b1;
          hcnt_s  = HCNT_ZERO;
`ifdef SPI_RX_CTRL_ABORT_EN
          aborted_s = abort_seen_r;
`endif
        end else begin
          hcnt_s = hcnt_r + HCNT_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b0;
        en_s    = 1'b0;
        hcnt_s  = HCNT_ZERO;
      end
    endcase

`ifdef SPI_RX_CTRL_ABORT_EN
    // Abort wins over normal sequencing while CS is active and SCLK may run.
    if (abort_i && ((state_r == ST_SETUP) || (state_r == ST_RUN))) begin
      state_s      = ST_HOLD;
      hcnt_s       = HCNT_ZERO;
      sclk_s       = 1'b0;
      en_s         = 1'b0;
      edge_s       = 1'b0;
      bit_cnt_s    = bit_cnt_r;
      abort_seen_s = 1'b1;
    end else begin
      abort_seen_s = abort_seen_s;
    end
`endif
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= ST_IDLE;
      div_r     <= HCNT_ZERO;
      hcnt_r    <= HCNT_ZERO;
      len_r     <= BIT_ZERO;
      bit_cnt_r <= BIT_ZERO;
      cs_n_r    <= 1'b1;
      sclk_r    <= 1'b0;
      edge_r    <= 1'b0;
      en_r      <= 1'b0;
      upd_r     <= 1'b0;
      done_r    <= 1'b0;
`ifdef SPI_RX_CTRL_ABORT_EN
      abort_seen_r <= 1'b0;
      aborted_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      hcnt_r    <= hcnt_s;
      len_r     <= len_s;
      bit_cnt_r <= bit_cnt_s;
      cs_n_r    <= cs_n_s;
      sclk_r    <= sclk_s;
      edge_r    <= edge_s;
      en_r      <= en_s;
      upd_r     <= upd_s;
      done_r    <= done_s;
`ifdef SPI_RX_CTRL_ABORT_EN
      abort_seen_r <= abort_seen_s;
      aborted_r    <= aborted_s;
`endif
    end
  end

  assign cmd_rdy_o            = (state_r == ST_IDLE);
  assign busy_o               = (state_r != ST_IDLE);
  assign done_o               = done_r;
  assign cs_n_o               = cs_n_r;
  assign sclk_o               = sclk_r;
  assign rx_en_o              = en_r;
  assign rx_edge_o            = edge_r;
  assign rx_bits_len_o        = len_r;
  assign rx_bits_len_update_o = upd_r;
`ifdef SPI_RX_CTRL_ABORT_EN
  assign aborted_o            = aborted_r;
`endif

endmodule
